// File: rtl/mem_addr_decoder.sv
`default_nettype none
// ============================================================================
// Module   : mem_addr_decoder
// Purpose  : Translates a 32-bit MIPS32 virtual byte address into a PA_W-bit
//            physical offset within either the global data window or the
//            stack window. Addresses that hit neither window are flagged
//            invalid. All outputs are registered (one cycle of latency).
//
// Ports    : clk       in   1     system clock, rising edge
//            rst       in   1     synchronous active-high reset
//            vAddr     in   32    virtual byte address from the CPU
//            pAddr     out  PA_W  offset into the selected window
//            iAddr     out  1     1 = address hits neither window
//            region    out  2     00 none, 01 data, 10 stack
//            fault     out  1     sticky miss flag      (MEMDEC_FAULT_LATCH_EN)
//            faultAddr out  32    address of first miss (MEMDEC_FAULT_LATCH_EN)
//
// Options  : MEMDEC_FAULT_LATCH_EN - adds the sticky fault / faultAddr capture.
//
// Revision : 1.0 - initial release
// ============================================================================
module mem_addr_decoder #(
  parameter logic [31:0] DATA_BASE  = 32'h1001_0000,
  parameter logic [31:0] STACK_BASE = 32'h7FFF_EFFC,
  parameter logic [31:0] WIN_SIZE   = 32'h0000_1000,
  parameter int          PA_W       = 11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     vAddr,
  output logic [PA_W-1:0] pAddr,
  output logic            iAddr,
`ifdef MEMDEC_FAULT_LATCH_EN
  output logic [1:0]      region,
  output logic            fault,
  output logic [31:0]     faultAddr
`else
  output logic [1:0]      region
`endif
);

  localparam logic [1:0] REG_NONE  = 2'b00;
  localparam logic [1:0] REG_DATA  = 2'b01;
  localparam logic [1:0] REG_STACK = 2'b10;

  // Offsets are formed by subtraction first; testing "base <= a" plus
  // "a - base < size" avoids the wrap-around that base+size could hit.
  logic [31:0] w_data_diff;
  logic [31:0] w_stack_diff;
  logic        w_data_hit;
  logic        w_stack_hit;

  logic [PA_W-1:0] pAddr_d,  pAddr_q;
  logic            iAddr_d,  iAddr_q;
  logic [1:0]      region_d, region_q;

  assign w_data_diff  = vAddr - DATA_BASE;
  assign w_stack_diff = vAddr - STACK_BASE;
  assign w_data_hit   = (vAddr >= DATA_BASE)  && (w_data_diff  < WIN_SIZE);
  assign w_stack_hit  = (vAddr >= STACK_BASE) && (w_stack_diff < WIN_SIZE);

  // Data window takes priority should parameters ever make them overlap.
  always_comb begin
    pAddr_d  = '0;
    iAddr_d  = 1'b1;
    region_d = REG_NONE;
    if (w_data_hit) begin
      pAddr_d  = w_data_diff[PA_W-1:0];
      iAddr_d  = 1'b0;
      region_d = REG_DATA;
    end else if (w_stack_hit) begin
      pAddr_d  = w_stack_diff[PA_W-1:0];
      iAddr_d  = 1'b0;
      region_d = REG_STACK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pAddr_q  <= '0;
      iAddr_q  <= 1'b0;
      region_q <= REG_NONE;
    end else begin
      pAddr_q  <= pAddr_d;
      iAddr_q  <= iAddr_d;
      region_q <= region_d;
    end
  end

  assign pAddr  = pAddr_q;
  assign iAddr  = iAddr_q;
  assign region = region_q;

`ifdef MEMDEC_FAULT_LATCH_EN
  logic        fault_q;
  logic [31:0] faultAddr_q;

  // Only the first miss is captured; the flag holds until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q     <= 1'b0;
      faultAddr_q <= '0;
    end else if (!fault_q && iAddr_d) begin
      fault_q     <= 1'b1;
      faultAddr_q <= vAddr;
    end
  end

  assign fault     = fault_q;
  assign faultAddr = faultAddr_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_addr_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_addr_decoder
// Purpose  : Directed self-checking bench for mem_addr_decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_addr_decoder;

  logic        clk;
  logic        rst;
  logic [31:0] vAddr;
  logic [10:0] pAddr;
  logic        iAddr;
  logic [1:0]  region;
`ifdef MEMDEC_FAULT_LATCH_EN
  logic        fault;
  logic [31:0] faultAddr;
`endif

  int n_checks = 0;
  int n_errors = 0;

  mem_addr_decoder dut (
    .clk      (clk),
    .rst      (rst),
    .vAddr    (vAddr),
    .pAddr    (pAddr),
    .iAddr    (iAddr),
`ifdef MEMDEC_FAULT_LATCH_EN
    .region   (region),
    .fault    (fault),
    .faultAddr(faultAddr)
`else
    .region   (region)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Present an address, let one edge register it, then check the outputs.
  task automatic dec(input string tag, input logic [31:0] a,
                     input logic [10:0] ep, input logic [1:0] er, input logic ei);
    vAddr = a;
    @(posedge clk);
    #1;
    chk({tag, ".pAddr"},  {21'd0, pAddr}, {21'd0, ep});
    chk({tag, ".region"}, {30'd0, region}, {30'd0, er});
    chk({tag, ".iAddr"},  {31'd0, iAddr}, {31'd0, ei});
  endtask

  initial begin
    rst   = 1'b1;
    vAddr = 32'h1001_0005;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.pAddr",  {21'd0, pAddr}, 32'd0);
    chk("rst.region", {30'd0, region}, 32'd0);
    chk("rst.iAddr",  {31'd0, iAddr}, 32'd0);
`ifdef MEMDEC_FAULT_LATCH_EN
    chk("rst.fault",     {31'd0, fault}, 32'd0);
    chk("rst.faultAddr", faultAddr, 32'd0);
`endif
    rst = 1'b0;
    dec("first", 32'h1001_0005, 11'h005, 2'b01, 1'b0);

    // Data sweep and top of window (offset 0xFFF truncates to 0x7FF)
    for (int i = 0; i < 8; i++)
      dec("dsweep", 32'h1001_0000 + i, 11'(i), 2'b01, 1'b0);
    dec("dtop",   32'h1001_0FFF, 11'h7FF, 2'b01, 1'b0);
    dec("dmid",   32'h1001_0802, 11'h002, 2'b01, 1'b0);

    // Stack sweep and edges
    for (int i = 0; i < 8; i++)
      dec("ssweep", 32'h7FFF_EFFC + i, 11'(i), 2'b10, 1'b0);
    dec("stop",   32'h7FFF_FFFB, 11'h7FF, 2'b10, 1'b0);
    dec("sabove", 32'h7FFF_FFFC, 11'h000, 2'b00, 1'b1);
    dec("sbelow", 32'h7FFF_EFFB, 11'h000, 2'b00, 1'b1);

    // Data edges (also exercise fault capture order when enabled)
    dec("dabove", 32'h1001_1000, 11'h000, 2'b00, 1'b1);
`ifdef MEMDEC_FAULT_LATCH_EN
    // First miss was 0x7FFFFFFC above; restart capture for the planned order.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    dec("fmiss1", 32'h1001_1000, 11'h000, 2'b00, 1'b1);
    dec("fmiss2", 32'h7FFF_FFFC, 11'h000, 2'b00, 1'b1);
    chk("fault.set",  {31'd0, fault}, 32'd1);
    chk("fault.addr", faultAddr, 32'h1001_1000);
    dec("fhit", 32'h1001_0001, 11'h001, 2'b01, 1'b0);
    chk("fault.hold", {31'd0, fault}, 32'd1);
    chk("fault.addrhold", faultAddr, 32'h1001_1000);
`endif
    dec("dbelow", 32'h1000_FFFF, 11'h000, 2'b00, 1'b1);

    // Back-to-back alternation
    dec("alt.d", 32'h1001_0003, 11'h003, 2'b01, 1'b0);
    dec("alt.s", 32'h7FFF_F000, 11'h004, 2'b10, 1'b0);
    dec("alt.m", 32'h0000_0000, 11'h000, 2'b00, 1'b1);
    dec("alt.d2", 32'h1001_0006, 11'h006, 2'b01, 1'b0);

    // Mid-stream reset wins over a valid hit on the same edge
    rst   = 1'b1;
    vAddr = 32'h7FFF_F001;
    @(posedge clk);
    #1;
    chk("mrst.pAddr",  {21'd0, pAddr}, 32'd0);
    chk("mrst.region", {30'd0, region}, 32'd0);
    chk("mrst.iAddr",  {31'd0, iAddr}, 32'd0);
`ifdef MEMDEC_FAULT_LATCH_EN
    chk("mrst.fault",     {31'd0, fault}, 32'd0);
    chk("mrst.faultAddr", faultAddr, 32'd0);
`endif
    rst = 1'b0;
    dec("post", 32'h7FFF_F001, 11'h005, 2'b10, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
